// File: rtl/cw305_seq_pkg.sv
// cw305_seq_pkg
//   Shared definitions for the CW305 crypto sequencer slice: the FSM state
//   encoding, default data-path widths and the cycle-count register width.
package cw305_seq_pkg;

  localparam int unsigned KEY_W_DEF  = 128;
  localparam int unsigned TEXT_W_DEF = 128;
  localparam int unsigned CYCLES_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cw305_rise_detect.sv
// cw305_rise_detect
//   Rising-edge detector for level signals coming from the register bank.
//   Ports:
//     clk_i   clock
//     rst_i   synchronous active-high reset (clears the history register)
//     sig_i   level input
//     rise_o  sig_i & ~previous(sig_i), combinational
//   Because the history register resets to 0, a level that is already high
//   when reset releases reports a rise in the first post-reset cycle.
module cw305_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/cw305_crypto_sequencer.sv
// cw305_crypto_sequencer
//   Turns a host GO edge into one framed crypto-core operation: latch
//   key/text (LOAD), start the core and hold the scope trigger (RUN), then
//   capture the result or abort after TIMEOUT RUN cycles.
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     go                     GO level; only its rising edge in IDLE acts
//     key_in, text_in        operands from the register bank
//     core_start             one-cycle start pulse (first RUN cycle)
//     core_key, core_text    operands latched in LOAD
//     core_done, core_result core completion pulse and its result
//     result_out             last captured result
//     busy                   high in LOAD and RUN
//     done, timeout          sticky status of the last operation
//     tio_trigger            scope trigger, high for every RUN cycle
//     cycles                 RUN-cycle count of the last operation
//   Optional feature: define CRYPTO_SEQ_CYCLE_COUNT_EN to get the cycles port.
//   All outputs are registered.
module cw305_crypto_sequencer
  import cw305_seq_pkg::*;
#(
  parameter int unsigned KEY_W   = KEY_W_DEF,
  parameter int unsigned TEXT_W  = TEXT_W_DEF,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [TEXT_W-1:0] text_in,
  output logic              core_start,
  output logic [KEY_W-1:0]  core_key,
  output logic [TEXT_W-1:0] core_text,
  input  logic              core_done,
  input  logic [TEXT_W-1:0] core_result,
  output logic [TEXT_W-1:0] result_out,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              tio_trigger
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
  ,
  output logic [CYCLES_W-1:0] cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e state_q, state_d;
  logic go_rise;
  logic expire;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [TEXT_W-1:0] text_q, text_d;
  logic [TEXT_W-1:0] result_q, result_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;
  logic start_q, start_d;
  logic trig_q, trig_d;
  logic busy_q, busy_d;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
  logic [CYCLES_W-1:0] cycles_q, cycles_d;
  logic [CYCLES_W-1:0] run_len;
  // cnt_q is 0 in the first RUN cycle, so the finished length is cnt_q + 1
  assign run_len = CYCLES_W'(cnt_q) + CYCLES_W'(1);
`endif

  cw305_rise_detect u_go_rise (
    .clk_i  (clk),
    .rst_i  (reset),
    .sig_i  (go),
    .rise_o (go_rise)
  );

  assign expire = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go_rise) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (core_done || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; the flags come from state_d so that the
  // registered copies line up with the state they describe.
  always_comb begin
    key_d     = key_q;
    text_d    = text_q;
    result_d  = result_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    trig_d    = (state_d == RUN);
    busy_d    = (state_d != IDLE);
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
    cycles_d  = cycles_q;
`endif
    unique case (state_q)
      LOAD: begin
        key_d     = key_in;
        text_d    = text_in;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        cnt_d     = '0;
        start_d   = 1'b1;
      end
      RUN: begin
        // Leaving RUN no later than cnt_q == TIMEOUT-1 keeps this from wrapping
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          result_d = core_result;
          done_d   = 1'b1;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
          cycles_d = run_len;
`endif
        end else if (expire) begin
          timeout_d = 1'b1;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
          cycles_d  = run_len;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= '0;
      text_q    <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
      cycles_q  <= '0;
`endif
    end else begin
      key_q     <= key_d;
      text_q    <= text_d;
      result_q  <= result_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
      cycles_q  <= cycles_d;
`endif
    end
  end

  assign core_start  = start_q;
  assign core_key    = key_q;
  assign core_text   = text_q;
  assign result_out  = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign tio_trigger = trig_q;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
  assign cycles      = cycles_q;
`endif

endmodule
